// File: rtl/mycpu_pkg.sv
// Shared LA32R pipeline definitions: bus widths, ALU op encoding, opcode fields
// and the inter-stage payload structs.
package mycpu_pkg;

  localparam int unsigned STAGE_1_TO_2_W = 64;
  localparam int unsigned STAGE_2_TO_3_W = 148;
  localparam int unsigned EX_FWD_W       = 40;
  localparam int unsigned MEM_FWD_W      = 39;
  localparam int unsigned WB_FWD_W       = 38;

  localparam int unsigned ALU_OP_W = 12;
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  // inst[31:15]
  localparam logic [16:0] OP17_ADD_W  = 17'h00020;
  localparam logic [16:0] OP17_SUB_W  = 17'h00022;
  localparam logic [16:0] OP17_SLT    = 17'h00024;
  localparam logic [16:0] OP17_SLTU   = 17'h00025;
  localparam logic [16:0] OP17_NOR    = 17'h00028;
  localparam logic [16:0] OP17_AND    = 17'h00029;
  localparam logic [16:0] OP17_OR     = 17'h0002a;
  localparam logic [16:0] OP17_XOR    = 17'h0002b;
  localparam logic [16:0] OP17_SLLI_W = 17'h00081;
  localparam logic [16:0] OP17_SRLI_W = 17'h00089;
  localparam logic [16:0] OP17_SRAI_W = 17'h00091;
  // inst[31:22]
  localparam logic [9:0]  OP10_ADDI_W = 10'h00a;
  localparam logic [9:0]  OP10_LD_W   = 10'h0a2;
  localparam logic [9:0]  OP10_ST_W   = 10'h0a6;
  // inst[31:25]
  localparam logic [6:0]  OP7_LU12I_W = 7'h0a;
  // inst[31:26]
  localparam logic [5:0]  OP6_JIRL    = 6'h13;
  localparam logic [5:0]  OP6_B       = 6'h14;
  localparam logic [5:0]  OP6_BL      = 6'h15;
  localparam logic [5:0]  OP6_BEQ     = 6'h16;
  localparam logic [5:0]  OP6_BNE     = 6'h17;

  typedef enum logic [2:0] {SRC2_REG, SRC2_SI12, SRC2_UI5, SRC2_SI20, SRC2_FOUR} src2_sel_e;
  typedef enum logic [2:0] {BR_NONE, BR_PC26, BR_EQ, BR_NE, BR_JIRL} br_kind_e;

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } ex_fwd_t;

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] value;
  } mem_fwd_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_fwd_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                load;
    logic                store;
    logic                rf_we;
    logic [4:0]          dest;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         rkd_value;
    logic [31:0]         pc;
  } id_bundle_t;

  // Operand selection with EX > MEM > WB > register-file priority; r0 is hardwired.
  function automatic logic [31:0] fwd_operand(input logic [4:0] src, input ex_fwd_t ex,
                                              input mem_fwd_t mem, input wb_fwd_t wb,
                                              input logic [31:0] rf_value);
    logic [31:0] operand;
    operand = rf_value;
    if (src == 5'd0) operand = '0;
    else if (ex.valid && ex.rf_we && ex.dest == src) operand = ex.result;
    else if (mem.valid && mem.rf_we && mem.dest == src) operand = mem.value;
    else if (wb.rf_we && wb.waddr == src) operand = wb.wdata;
    return operand;
  endfunction

endpackage

// File: rtl/stage_2_id_regfile.sv
// 32x32 register file, two read ports and one write port; a read of the register
// being written in the same cycle returns the incoming data.
module regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/stage_2_id.sv
// LA32R instruction-decode stage: bundle latch, register read with forwarding,
// load-use stall, branch resolution and the valid/allow handshake to EX.
module stage_2_id
  import mycpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_1,
  input  logic [STAGE_1_TO_2_W-1:0] stage_1_to_2,
  output logic                      allow_2,
  output logic                      br_taken,
  output logic [31:0]               br_target,
  output logic                      valid_2,
  input  logic                      allow_3,
  output logic [STAGE_2_TO_3_W-1:0] stage_2_to_3,
  input  logic [EX_FWD_W-1:0]       ex_fwd,
  input  logic [MEM_FWD_W-1:0]      mem_fwd,
  input  logic [WB_FWD_W-1:0]       wb_fwd
);

  ex_fwd_t    ex;
  mem_fwd_t   mem;
  wb_fwd_t    wb;
  id_bundle_t bundle;

  logic        valid_r;
  logic [31:0] inst_r;
  logic [31:0] pc_r;

  logic [4:0]  rd, rj, rk, r2_addr;
  logic [31:0] rf_rdata1, rf_rdata2, rj_val, r2_val;
  logic [ALU_OP_W-1:0] alu_op;
  logic        is_load, is_store, rf_we, use_rj, use_r2, r2_is_rd, link, r3, sh;
  logic [4:0]  dest;
  src2_sel_e   src2_sel;
  br_kind_e    br_kind;
  logic        load_use, ready_go, br_cond;
  logic [31:0] off16, off26, src1, src2;

  assign ex  = ex_fwd;
  assign mem = mem_fwd;
  assign wb  = wb_fwd;

  assign rd = inst_r[4:0];
  assign rj = inst_r[9:5];
  assign rk = inst_r[14:10];

  // Bundle register; a bundle arriving while a branch redirects is wrong-path.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      inst_r  <= '0;
      pc_r    <= RESET_PC;
    end else if (valid_1 && allow_2) begin
      valid_r <= ~br_taken;
      inst_r  <= stage_1_to_2[63:32];
      pc_r    <= stage_1_to_2[31:0];
    end else if (allow_3 && ready_go) begin
      valid_r <= 1'b0;
    end
  end

  always_comb begin
    alu_op   = '0;
    is_load  = 1'b0;
    is_store = 1'b0;
    rf_we    = 1'b0;
    dest     = '0;
    use_rj   = 1'b0;
    use_r2   = 1'b0;
    r2_is_rd = 1'b0;
    link     = 1'b0;
    r3       = 1'b0;
    sh       = 1'b0;
    src2_sel = SRC2_REG;
    br_kind  = BR_NONE;

    case (inst_r[31:15])
      OP17_ADD_W:  begin alu_op[ALU_ADD]  = 1'b1; r3 = 1'b1; end
      OP17_SUB_W:  begin alu_op[ALU_SUB]  = 1'b1; r3 = 1'b1; end
      OP17_SLT:    begin alu_op[ALU_SLT]  = 1'b1; r3 = 1'b1; end
      OP17_SLTU:   begin alu_op[ALU_SLTU] = 1'b1; r3 = 1'b1; end
      OP17_NOR:    begin alu_op[ALU_NOR]  = 1'b1; r3 = 1'b1; end
      OP17_AND:    begin alu_op[ALU_AND]  = 1'b1; r3 = 1'b1; end
      OP17_OR:     begin alu_op[ALU_OR]   = 1'b1; r3 = 1'b1; end
      OP17_XOR:    begin alu_op[ALU_XOR]  = 1'b1; r3 = 1'b1; end
      OP17_SLLI_W: begin alu_op[ALU_SLL]  = 1'b1; sh = 1'b1; end
      OP17_SRLI_W: begin alu_op[ALU_SRL]  = 1'b1; sh = 1'b1; end
      OP17_SRAI_W: begin alu_op[ALU_SRA]  = 1'b1; sh = 1'b1; end
      default: ;
    endcase
    if (r3) begin
      rf_we = 1'b1; dest = rd; use_rj = 1'b1; use_r2 = 1'b1;
    end
    if (sh) begin
      rf_we = 1'b1; dest = rd; use_rj = 1'b1; src2_sel = SRC2_UI5;
    end

    case (inst_r[31:22])
      OP10_ADDI_W: begin
        alu_op[ALU_ADD] = 1'b1; rf_we = 1'b1; dest = rd; use_rj = 1'b1; src2_sel = SRC2_SI12;
      end
      OP10_LD_W: begin
        alu_op[ALU_ADD] = 1'b1; rf_we = 1'b1; dest = rd; use_rj = 1'b1; src2_sel = SRC2_SI12;
        is_load = 1'b1;
      end
      OP10_ST_W: begin
        alu_op[ALU_ADD] = 1'b1; use_rj = 1'b1; use_r2 = 1'b1; r2_is_rd = 1'b1;
        src2_sel = SRC2_SI12; is_store = 1'b1;
      end
      default: ;
    endcase

    if (inst_r[31:25] == OP7_LU12I_W) begin
      alu_op[ALU_LUI] = 1'b1; rf_we = 1'b1; dest = rd; src2_sel = SRC2_SI20;
    end

    // Link instructions compute pc + 4 in the ALU.
    case (inst_r[31:26])
      OP6_JIRL: begin
        alu_op[ALU_ADD] = 1'b1; rf_we = 1'b1; dest = rd; link = 1'b1; use_rj = 1'b1;
        src2_sel = SRC2_FOUR; br_kind = BR_JIRL;
      end
      OP6_B: br_kind = BR_PC26;
      OP6_BL: begin
        alu_op[ALU_ADD] = 1'b1; rf_we = 1'b1; dest = 5'd1; link = 1'b1;
        src2_sel = SRC2_FOUR; br_kind = BR_PC26;
      end
      OP6_BEQ: begin
        use_rj = 1'b1; use_r2 = 1'b1; r2_is_rd = 1'b1; br_kind = BR_EQ;
      end
      OP6_BNE: begin
        use_rj = 1'b1; use_r2 = 1'b1; r2_is_rd = 1'b1; br_kind = BR_NE;
      end
      default: ;
    endcase
  end

  assign r2_addr = r2_is_rd ? rd : rk;

  regfile u_regfile (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rf_rdata1),
    .raddr2 (r2_addr),
    .rdata2 (rf_rdata2),
    .we     (wb.rf_we),
    .waddr  (wb.waddr),
    .wdata  (wb.wdata)
  );

  assign rj_val = fwd_operand(rj, ex, mem, wb, rf_rdata1);
  assign r2_val = fwd_operand(r2_addr, ex, mem, wb, rf_rdata2);

  // A load still in EX cannot forward; stall only on sources actually read.
  assign load_use = valid_r && ex.valid && ex.rf_we && ex.is_load &&
                    ((use_rj && rj != 5'd0 && ex.dest == rj) ||
                     (use_r2 && r2_addr != 5'd0 && ex.dest == r2_addr));
  assign ready_go = ~load_use;
  assign allow_2  = ~valid_r | (ready_go & allow_3);
  assign valid_2  = valid_r & ready_go;

  assign off16 = {{14{inst_r[25]}}, inst_r[25:10], 2'b00};
  assign off26 = {{4{inst_r[9]}}, inst_r[9:0], inst_r[25:10], 2'b00};

  always_comb begin
    br_cond = 1'b0;
    case (br_kind)
      BR_PC26, BR_JIRL: br_cond = 1'b1;
      BR_EQ:            br_cond = (rj_val == r2_val);
      BR_NE:            br_cond = (rj_val != r2_val);
      default:          br_cond = 1'b0;
    endcase
  end

  assign br_taken  = valid_r & ready_go & br_cond;
  assign br_target = ((br_kind == BR_JIRL) ? rj_val : pc_r) +
                     ((br_kind == BR_PC26) ? off26 : off16);

  assign src1 = link ? pc_r : (use_rj ? rj_val : 32'd0);

  always_comb begin
    src2 = r2_val;
    case (src2_sel)
      SRC2_SI12: src2 = {{20{inst_r[21]}}, inst_r[21:10]};
      SRC2_UI5:  src2 = {27'd0, inst_r[14:10]};
      SRC2_SI20: src2 = {inst_r[24:5], 12'd0};
      SRC2_FOUR: src2 = 32'd4;
      default:   src2 = r2_val;
    endcase
  end

  always_comb begin
    bundle.alu_op    = alu_op;
    bundle.load      = is_load;
    bundle.store     = is_store;
    bundle.rf_we     = rf_we;
    bundle.dest      = dest;
    bundle.src1      = src1;
    bundle.src2      = src2;
    bundle.rkd_value = use_r2 ? r2_val : 32'd0;
    bundle.pc        = pc_r;
  end

  assign stage_2_to_3 = bundle;

endmodule

// File: tb/tb_stage_2_id.sv
// Directed, table-driven bench for stage_2_id plus hand sequences for
// branch squash, load-use stall, back-pressure and reset during a stall.
module tb_stage_2_id;
  import mycpu_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      valid_1;
  logic [STAGE_1_TO_2_W-1:0] stage_1_to_2;
  logic                      allow_2, br_taken, valid_2, allow_3;
  logic [31:0]               br_target;
  logic [STAGE_2_TO_3_W-1:0] stage_2_to_3;
  logic [EX_FWD_W-1:0]       ex_fwd;
  logic [MEM_FWD_W-1:0]      mem_fwd;
  logic [WB_FWD_W-1:0]       wb_fwd;
  id_bundle_t                pl;

  int errors = 0;
  int checks = 0;

  stage_2_id #(.RESET_PC(32'h1c000000)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_1      (valid_1),
    .stage_1_to_2 (stage_1_to_2),
    .allow_2      (allow_2),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .valid_2      (valid_2),
    .allow_3      (allow_3),
    .stage_2_to_3 (stage_2_to_3),
    .ex_fwd       (ex_fwd),
    .mem_fwd      (mem_fwd),
    .wb_fwd       (wb_fwd)
  );

  always #5 clk = ~clk;
  assign pl = stage_2_to_3;

  typedef struct {
    string       name;
    logic [31:0] inst, pc;
    logic [39:0] ex;
    logic [38:0] mem;
    logic [37:0] wb;
    logic        a3, v2, al2, bt;
    logic [31:0] tgt;
    logic [2:0]  chk;  // {target, ops, sources}
    logic [11:0] alu;
    logic        ld, st, we;
    logic [4:0]  dst;
    logic [31:0] s1, s2, rkd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [39:0] ex, input logic [38:0] mem, input logic [37:0] wb,
                              input logic a3, input logic v2, input logic al2, input logic bt,
                              input logic [31:0] tgt, input logic [2:0] chk, input logic [11:0] alu,
                              input logic ld, input logic st, input logic we, input logic [4:0] dst,
                              input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd);
    vec_t v;
    v.name = n; v.inst = inst; v.pc = pc; v.ex = ex; v.mem = mem; v.wb = wb;
    v.a3 = a3; v.v2 = v2; v.al2 = al2; v.bt = bt; v.tgt = tgt; v.chk = chk;
    v.alu = alu; v.ld = ld; v.st = st; v.we = we; v.dst = dst; v.s1 = s1; v.s2 = s2; v.rkd = rkd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ex_fwd = '0; mem_fwd = '0; wb_fwd = '0; allow_3 = 1'b1;
  endtask

  task automatic run_vec(input vec_t t);
    valid_1 = 1'b1;
    stage_1_to_2 = {t.inst, t.pc};
    idle_bus();
    tick();
    valid_1 = 1'b0;
    ex_fwd = t.ex; mem_fwd = t.mem; wb_fwd = t.wb; allow_3 = t.a3;
    #1;
    chk({t.name, ".valid_2"}, 32'(valid_2), 32'(t.v2));
    chk({t.name, ".allow_2"}, 32'(allow_2), 32'(t.al2));
    chk({t.name, ".br_taken"}, 32'(br_taken), 32'(t.bt));
    chk({t.name, ".pc"}, pl.pc, t.pc);
    if (t.chk[2]) chk({t.name, ".br_target"}, br_target, t.tgt);
    if (t.chk[1]) begin
      chk({t.name, ".alu_op"}, 32'(pl.alu_op), 32'(t.alu));
      chk({t.name, ".ld_st_we"}, 32'({pl.load, pl.store, pl.rf_we}), 32'({t.ld, t.st, t.we}));
      chk({t.name, ".dest"}, 32'(pl.dest), 32'(t.dst));
    end
    if (t.chk[0]) begin
      chk({t.name, ".src1"}, pl.src1, t.s1);
      chk({t.name, ".src2"}, pl.src2, t.s2);
      chk({t.name, ".rkd"}, pl.rkd_value, t.rkd);
    end
    idle_bus();
    tick();
  endtask

  localparam logic [39:0] EX0  = '0;
  localparam logic [38:0] MEM0 = '0;
  localparam logic [37:0] WB0  = '0;
  localparam logic [31:0] PC   = 32'h1c000100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk("addi", 32'h02800401, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h001, 0, 0, 1, 5'd1, 32'h0, 32'h1, 32'h0));
    tbl.push_back(mk("add", 32'h00100C45, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h001, 0, 0, 1, 5'd5, 32'h10, 32'h30, 32'h30));
    tbl.push_back(mk("sub", 32'h00110887, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h002, 0, 0, 1, 5'd7, 32'h44, 32'h10, 32'h10));
    tbl.push_back(mk("slli", 32'h00408C88, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h100, 0, 0, 1, 5'd8, 32'h44, 32'h3, 32'h0));
    tbl.push_back(mk("srai", 32'h004890C8, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h400, 0, 0, 1, 5'd8, 32'hfffffff0, 32'h4, 32'h0));
    tbl.push_back(mk("lu12i", 32'h142468A9, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h800, 0, 0, 1, 5'd9, 32'h0, 32'h12345000, 32'h0));
    tbl.push_back(mk("ldw", 32'h28BFF04A, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h001, 1, 0, 1, 5'd10, 32'h10, 32'hfffffffc, 32'h0));
    tbl.push_back(mk("stw", 32'h29802043, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h001, 0, 1, 0, 5'd0, 32'h10, 32'h8, 32'h30));
    tbl.push_back(mk("nor", 32'h00140C4B, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h020, 0, 0, 1, 5'd11, 32'h10, 32'h30, 32'h30));
    tbl.push_back(mk("ex_over_mem", 32'h00100065, PC, {1'b1, 1'b1, 1'b0, 5'd3, 32'd11},
                     {1'b1, 1'b1, 5'd3, 32'd22}, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h001, 0, 0, 1, 5'd5, 32'd11, 32'h0, 32'h0));
    tbl.push_back(mk("dest0", 32'h00100805, PC, {1'b1, 1'b1, 1'b0, 5'd0, 32'd99},
                     {1'b1, 1'b1, 5'd0, 32'd99}, WB0, 1, 1, 1, 0, 0, 3'b011,
                     12'h001, 0, 0, 1, 5'd5, 32'h0, 32'h10, 32'h10));
    tbl.push_back(mk("mem_fwd", 32'h00101085, PC, EX0, {1'b1, 1'b1, 5'd4, 32'd7}, WB0,
                     1, 1, 1, 0, 0, 3'b011, 12'h001, 0, 0, 1, 5'd5, 32'd7, 32'd7, 32'd7));
    tbl.push_back(mk("wb_fwd", 32'h00100D85, PC, EX0, MEM0, {1'b1, 5'd12, 32'h55},
                     1, 1, 1, 0, 0, 3'b011, 12'h001, 0, 0, 1, 5'd5, 32'h55, 32'h30, 32'h30));
    tbl.push_back(mk("mem_invalid", 32'h00101085, PC, EX0, {1'b0, 1'b1, 5'd4, 32'd7}, WB0,
                     1, 1, 1, 0, 0, 3'b011, 12'h001, 0, 0, 1, 5'd5, 32'h44, 32'h44, 32'h44));
    tbl.push_back(mk("ex_no_we", 32'h00101085, PC, {1'b1, 1'b0, 1'b0, 5'd4, 32'd9}, MEM0, WB0,
                     1, 1, 1, 0, 0, 3'b011, 12'h001, 0, 0, 1, 5'd5, 32'h44, 32'h44, 32'h44));
    tbl.push_back(mk("bne_taken", 32'h5C004043, 32'h1c000200, EX0, MEM0, WB0, 1, 1, 1, 1,
                     32'h1c000240, 3'b100, 12'h0, 0, 0, 0, 5'd0, 0, 0, 0));
    tbl.push_back(mk("beq_not", 32'h58004043, 32'h1c000200, EX0, MEM0, WB0, 1, 1, 1, 0,
                     32'h1c000240, 3'b100, 12'h0, 0, 0, 0, 5'd0, 0, 0, 0));
    tbl.push_back(mk("jirl", 32'h4C000881, 32'h1c000300, EX0, MEM0, WB0, 1, 1, 1, 1,
                     32'h0000004c, 3'b111, 12'h001, 0, 0, 1, 5'd1, 32'h1c000300, 32'h4, 32'h0));
    tbl.push_back(mk("b_back", 32'h53FFFFFF, 32'h1c000400, EX0, MEM0, WB0, 1, 1, 1, 1,
                     32'h1c0003fc, 3'b100, 12'h0, 0, 0, 0, 5'd0, 0, 0, 0));
    tbl.push_back(mk("bl", 32'h54010000, 32'h1c000020, EX0, MEM0, WB0, 1, 1, 1, 1,
                     32'h1c000120, 3'b111, 12'h001, 0, 0, 1, 5'd1, 32'h1c000020, 32'h4, 32'h0));
    tbl.push_back(mk("undecoded", 32'hFFFFFFFF, PC, EX0, MEM0, WB0, 1, 1, 1, 0, 0, 3'b010,
                     12'h000, 0, 0, 0, 5'd0, 0, 0, 0));
    tbl.push_back(mk("load_use", 32'h00101085, PC, {1'b1, 1'b1, 1'b1, 5'd4, 32'd0}, MEM0, WB0,
                     1, 0, 0, 0, 0, 3'b010, 12'h001, 0, 0, 1, 5'd5, 0, 0, 0));
    tbl.push_back(mk("ld_unused_src", 32'h00408C88, PC, {1'b1, 1'b1, 1'b1, 5'd3, 32'd0}, MEM0,
                     WB0, 1, 1, 1, 0, 0, 3'b011, 12'h100, 0, 0, 1, 5'd8, 32'h44, 32'h3, 32'h0));
    tbl.push_back(mk("hold", 32'h00100C45, PC, EX0, MEM0, WB0, 0, 1, 0, 0, 0, 3'b011,
                     12'h001, 0, 0, 1, 5'd5, 32'h10, 32'h30, 32'h30));

    reset = 1'b1; valid_1 = 1'b0; stage_1_to_2 = '0;
    idle_bus();
    tick();
    tick();
    chk("reset.valid_2", 32'(valid_2), 32'd0);
    chk("reset.br_taken", 32'(br_taken), 32'd0);
    chk("reset.allow_2", 32'(allow_2), 32'd1);
    chk("reset.pc", pl.pc, 32'h1c000000);
    reset = 1'b0;

    // Preload the register file through the WB write port.
    wb_fwd = {1'b1, 5'd2, 32'h10};       tick();
    wb_fwd = {1'b1, 5'd3, 32'h30};       tick();
    wb_fwd = {1'b1, 5'd4, 32'h44};       tick();
    wb_fwd = {1'b1, 5'd6, 32'hfffffff0}; tick();
    wb_fwd = '0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Taken beq drops the bundle fetched behind it.
    valid_1 = 1'b1;
    stage_1_to_2 = {32'h58000800, 32'h1c000010};
    tick();
    stage_1_to_2 = {32'h02800401, 32'h1c000014};
    #1;
    chk("beq0.br_taken", 32'(br_taken), 32'd1);
    chk("beq0.br_target", br_target, 32'h1c000018);
    chk("beq0.allow_2", 32'(allow_2), 32'd1);
    tick();
    valid_1 = 1'b0;
    #1;
    chk("squash.valid_2", 32'(valid_2), 32'd0);
    chk("squash.pc", pl.pc, 32'h1c000014);
    chk("squash.br_taken", 32'(br_taken), 32'd0);
    tick();

    // Load-use stall for one cycle, then MEM supplies the value.
    valid_1 = 1'b1;
    stage_1_to_2 = {32'h00101085, 32'h1c000050};
    tick();
    stage_1_to_2 = {32'h02800401, 32'h1c000054};
    ex_fwd = {1'b1, 1'b1, 1'b1, 5'd4, 32'd0};
    #1;
    chk("stall.allow_2", 32'(allow_2), 32'd0);
    chk("stall.valid_2", 32'(valid_2), 32'd0);
    tick();
    ex_fwd = '0;
    mem_fwd = {1'b1, 1'b1, 5'd4, 32'd7};
    #1;
    chk("unstall.valid_2", 32'(valid_2), 32'd1);
    chk("unstall.allow_2", 32'(allow_2), 32'd1);
    chk("unstall.pc", pl.pc, 32'h1c000050);
    chk("unstall.src1", pl.src1, 32'd7);
    chk("unstall.src2", pl.src2, 32'd7);
    tick();
    valid_1 = 1'b0;
    mem_fwd = '0;
    #1;
    chk("after_stall.pc", pl.pc, 32'h1c000054);
    chk("after_stall.valid_2", 32'(valid_2), 32'd1);
    tick();

    // EX back-pressure for three cycles.
    valid_1 = 1'b1;
    stage_1_to_2 = {32'h02800401, 32'h1c000060};
    tick();
    stage_1_to_2 = {32'h00100C45, 32'h1c000064};
    allow_3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d.allow_2", i), 32'(allow_2), 32'd0);
      chk($sformatf("bp%0d.valid_2", i), 32'(valid_2), 32'd1);
      chk($sformatf("bp%0d.pc", i), pl.pc, 32'h1c000060);
      tick();
    end
    allow_3 = 1'b1;
    #1;
    chk("release.allow_2", 32'(allow_2), 32'd1);
    tick();
    valid_1 = 1'b0;
    #1;
    chk("release.pc", pl.pc, 32'h1c000064);
    chk("release.valid_2", 32'(valid_2), 32'd1);
    tick();

    // Branch held during a load-use stall; reset during the stall discards it.
    valid_1 = 1'b1;
    stage_1_to_2 = {32'h4C000080, 32'h1c000070};
    tick();
    valid_1 = 1'b0;
    ex_fwd = {1'b1, 1'b1, 1'b1, 5'd4, 32'd0};
    #1;
    chk("jstall.br_taken", 32'(br_taken), 32'd0);
    chk("jstall.valid_2", 32'(valid_2), 32'd0);
    ex_fwd = '0;
    #1;
    chk("jfree.br_taken", 32'(br_taken), 32'd1);
    chk("jfree.br_target", br_target, 32'h00000044);
    ex_fwd = {1'b1, 1'b1, 1'b1, 5'd4, 32'd0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ex_fwd = '0;
    #1;
    chk("rst_stall.valid_2", 32'(valid_2), 32'd0);
    chk("rst_stall.br_taken", 32'(br_taken), 32'd0);
    chk("rst_stall.allow_2", 32'(allow_2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
